// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state/mode encodings and helpers for the round-robin arbiter
package arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Bits needed to hold values 0..value-1, never less than one bit
    function automatic int clog2_min1(input int unsigned value);
        int r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // One-hot decode of an index; callers truncate to their own width
    function automatic logic [31:0] onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational first-set-bit picker with rotating start point
module arb_pick
    import arb_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [(1<<W)-1:0] cand,
    input  logic [W-1:0]      start,
    input  logic              mode,
    output logic [W-1:0]      pick,
    output logic              any
);

    localparam int N = 1 << W;

    logic [W-1:0] base;
    logic [W-1:0] idx;

    // Fixed priority is just a round-robin scan that always starts at index 0
    assign base = (mode == MODE_RR) ? start : '0;

    // Scan base, base+1, ... with natural W-bit wrap; first candidate wins
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int i = 0; i < N; i++) begin
            idx = base + W'(i);
            if (!any && cand[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter_rr.sv
// rtl/arbiter_rr.sv - registered N-way fixed/round-robin arbiter with optional hold limit
module arbiter_rr
    import arb_pkg::*;
#(
    parameter int W        = 2,
    parameter int MAX_HOLD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [(1<<W)-1:0] req,
    input  logic              mode,
    output logic [(1<<W)-1:0] gnt,
    output logic [W-1:0]      gnt_id,
    output logic              gnt_valid,
    output logic              timeout
);

    localparam int N  = 1 << W;
    localparam int CW = clog2_min1(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_START = (MAX_HOLD == 0) ? '0 : CW'(1);

    state_t        state;
    logic [W-1:0]  ptr;
    logic [CW-1:0] cnt;

    logic          owner_req;
    logic          limit_hit;
    logic [N-1:0]  owner_mask;
    logic [N-1:0]  cand;
    logic [W-1:0]  pick;
    logic          any;
    logic          do_grant;
    logic [W-1:0]  next_id;

    assign owner_req  = req[gnt_id];
    assign owner_mask = N'(onehot(32'(gnt_id)));

    // Forced release: owner still asking but has used its full hold budget
    assign limit_hit = (MAX_HOLD != 0) && (state == ST_GRANT) && owner_req && (cnt == HOLD_MAX);

    // On forced release the owner is hidden so anyone else waiting gets a turn
    assign cand = limit_hit ? (req & ~owner_mask) : req;

    arb_pick #(.W(W)) u_pick (
        .cand  (cand),
        .start (ptr),
        .mode  (mode),
        .pick  (pick),
        .any   (any)
    );

    // A grant is issued from IDLE, on release with a winner, or on any forced release
    assign do_grant = ((state == ST_IDLE) && any) ||
                      ((state == ST_GRANT) && ((!owner_req && any) || limit_hit));

    // With nobody else waiting at a forced release, the owner is simply re-granted
    assign next_id = any ? pick : gnt_id;

    // Grant FSM: registered outputs, rr pointer and hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            timeout <= 1'b0;
            if (do_grant) begin
                state     <= ST_GRANT;
                gnt       <= N'(onehot(32'(next_id)));
                gnt_id    <= next_id;
                gnt_valid <= 1'b1;
                timeout   <= limit_hit;
                ptr       <= next_id + W'(1);
                cnt       <= CNT_START;
            end else if ((state == ST_GRANT) && !owner_req) begin
                state     <= ST_IDLE;
                gnt       <= '0;
                gnt_valid <= 1'b0;
                cnt       <= '0;
            end else if ((state == ST_GRANT) && (MAX_HOLD != 0)) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_arbiter_rr.sv
// tb/tb_arbiter_rr.sv - directed table-driven bench for arbiter_rr
module tb_arbiter_rr;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [3:0] req;

    logic [3:0] gnt0, gnt4;
    logic [1:0] id0, id4;
    logic       valid0, valid4;
    logic       to0, to4;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    arbiter_rr #(.W(2), .MAX_HOLD(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt0),
        .gnt_id    (id0),
        .gnt_valid (valid0),
        .timeout   (to0)
    );

    arbiter_rr #(.W(2), .MAX_HOLD(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt4),
        .gnt_id    (id4),
        .gnt_valid (valid4),
        .timeout   (to4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic m, input logic [3:0] rq,
                       input logic [3:0] g, input logic [1:0] id,
                       input logic v, input logic t);
        vec_t e;
        e.rst = r; e.mode = m; e.req = rq;
        e.gnt = g; e.id = id; e.valid = v; e.to = t;
        tbl.push_back(e);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic r, input logic m, input logic [3:0] rq);
        logic [3:0] e0, e4;
        @(negedge clk);
        rst  = r;
        mode = m;
        req  = rq;
        @(posedge clk);
        #1;
        e0 = valid0 ? (4'b0001 << id0) : 4'b0000;
        e4 = valid4 ? (4'b0001 << id4) : 4'b0000;
        check("onehot_dut0", 32'(gnt0), 32'(e0));
        check("onehot_dut4", 32'(gnt4), 32'(e4));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        mode = 1'b0;
        req  = 4'b0000;

        // rst, mode, req, gnt, id, valid, timeout  (MAX_HOLD=0 instance)
        add(1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].mode, tbl[i].req);
            check($sformatf("v%0d gnt", i),       32'(gnt0),   32'(tbl[i].gnt));
            check($sformatf("v%0d gnt_id", i),    32'(id0),    32'(tbl[i].id));
            check($sformatf("v%0d gnt_valid", i), 32'(valid0), 32'(tbl[i].valid));
            check($sformatf("v%0d timeout", i),   32'(to0),    32'(tbl[i].to));
        end

        // Hold limit 4, all requesting: 0,1,2,3,0 for exactly 4 cycles each
        step(1'b1, 1'b1, 4'b1111);
        check("hl_rst gnt",     32'(gnt4),   32'd0);
        check("hl_rst gnt_id",  32'(id4),    32'd0);
        check("hl_rst valid",   32'(valid4), 32'd0);
        check("hl_rst timeout", 32'(to4),    32'd0);
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                logic [1:0] eid;
                eid = 2'(g % 4);
                step(1'b0, 1'b1, 4'b1111);
                check($sformatf("rot g%0d c%0d gnt_id", g, c), 32'(id4), 32'(eid));
                check($sformatf("rot g%0d c%0d gnt", g, c), 32'(gnt4), 32'(4'b0001 << eid));
                check($sformatf("rot g%0d c%0d valid", g, c), 32'(valid4), 32'd1);
                check($sformatf("rot g%0d c%0d timeout", g, c), 32'(to4),
                      ((g > 0) && (c == 0)) ? 32'd1 : 32'd0);
            end
        end

        // Hold limit 4, lone requester: continuous grant, timeout every 4 cycles
        step(1'b1, 1'b1, 4'b0100);
        check("solo_rst valid", 32'(valid4), 32'd0);
        for (int c = 0; c < 13; c++) begin
            step(1'b0, 1'b1, 4'b0100);
            check($sformatf("solo c%0d gnt", c), 32'(gnt4), 32'(4'b0100));
            check($sformatf("solo c%0d gnt_id", c), 32'(id4), 32'd2);
            check($sformatf("solo c%0d valid", c), 32'(valid4), 32'd1);
            check($sformatf("solo c%0d timeout", c), 32'(to4),
                  ((c > 0) && (c % 4 == 0)) ? 32'd1 : 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
